controller_seq: RTL and testbench

- Sequential, parametrised successor to the single-cycle wide-ROM instruction decoder.
- Owns the program counter. Fetches one 48-bit instruction from a narrow program ROM over several beats into an instruction register (IR).
- Then runs a one-cycle EXEC phase: decodes fields, evaluates the condition against the active-low flags, and drives active-low device selects.
- Sits between program ROM, flag register and the bus devices/ALU.

---
 rtl/controller_seq.sv | 144 ++++++++++++++
 tb/tb_controller_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_seq.sv
// Multi-beat fetch / single-cycle EXEC instruction sequencer with active-low device decode.
// Optional jump support is compiled in with `define CTRL_JUMP_EN.
module controller_seq #(
    parameter  int PCW    = 16,
    parameter  int ROMW   = 8,
    parameter  int NFLAGS = 10,
    localparam int BEATS  = 48 / ROMW,
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic            clk,
    input  logic            _mr,
    input  logic [ROMW-1:0] rom_data,
    input  logic            rom_valid,
    output logic [BW-1:0]   rom_beat,
    output logic [PCW-1:0]  pc,
    input  logic [NFLAGS-1:0] _flags,
    input  logic            stall,
    input  logic [PCW-1:0]  pc_in,
    input  logic            _pc_load,
    output logic            exec,
    output logic [4:0]      alu_op,
    output logic [2:0]      abus_dev,
    output logic [2:0]      bbus_dev,
    output logic [3:0]      targ_dev,
    output logic [7:0]      direct_address_hi,
    output logic [7:0]      direct_address_lo,
    output logic [7:0]      immed8,
    output logic            _addrmode_register,
    output logic            _addrmode_direct,
    output logic [7:0]      _adev_sel,
    output logic [7:0]      _bdev_sel,
    output logic [15:0]     _tdev_sel,
    output logic            _set_flags,
    output logic            _do_exec
);

    typedef enum logic {ST_FETCH, ST_EXEC} state_e;

    localparam logic [PCW-1:0] PC_ONE    = PCW'(1);
    localparam logic [BW-1:0]  BEAT_ONE  = BW'(1);
    localparam logic [BW-1:0]  BEAT_LAST = BW'(BEATS - 1);

    state_e          state_q;
    logic [PCW-1:0]  pc_q;
    logic [PCW-1:0]  pc_d;
    logic [BW-1:0]   beat_q;
    logic [47:0]     ir_q;
    logic            exec_q;
    logic [3:0]      cond;
    logic            cond_fail;
    logic            do_exec_n;

    // Condition is evaluated against the live flags; outside EXEC it reads as "not executing".
    always_comb begin
        cond      = ir_q[32:29];
        cond_fail = 1'b1;
        if (cond == 4'd0) begin
            cond_fail = 1'b0;
        end else begin
            for (int k = 0; k < NFLAGS; k++) begin
                if (int'(cond) == k + 1) begin
                    cond_fail = _flags[k];
                end
            end
        end
        do_exec_n = cond_fail | ~exec_q;
    end

`ifdef CTRL_JUMP_EN
    always_comb begin
        pc_d = pc_q + PC_ONE;
        if (!_pc_load && !do_exec_n) begin
            pc_d = pc_in;
        end
    end
    logic unused_reserved;
    assign unused_reserved = ^ir_q[27:25];
`else
    assign pc_d = pc_q + PC_ONE;
    logic unused_jump;
    assign unused_jump = ^{pc_in, _pc_load, ir_q[27:25]};
`endif

    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            beat_q  <= '0;
            ir_q    <= '0;
            exec_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (rom_valid) begin
                        // Beat 0 fills the most significant slice of the IR.
                        ir_q[(BEATS - 1 - int'(beat_q)) * ROMW +: ROMW] <= rom_data;
                        if (beat_q == BEAT_LAST) begin
                            beat_q  <= '0;
                            state_q <= ST_EXEC;
                            exec_q  <= 1'b1;
                        end else begin
                            beat_q <= beat_q + BEAT_ONE;
                        end
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc_q    <= pc_d;
                        state_q <= ST_FETCH;
                        exec_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign pc                 = pc_q;
    assign rom_beat           = beat_q;
    assign exec               = exec_q;
    assign alu_op             = ir_q[47:43];
    assign targ_dev           = ir_q[42:39];
    assign abus_dev           = ir_q[38:36];
    assign bbus_dev           = ir_q[35:33];
    assign direct_address_hi  = ir_q[23:16];
    assign direct_address_lo  = ir_q[15:8];
    assign immed8             = ir_q[7:0];
    assign _addrmode_register = ir_q[24];
    assign _addrmode_direct   = ~ir_q[24];
    assign _do_exec           = do_exec_n;
    assign _set_flags         = ir_q[28] | do_exec_n | ~exec_q;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bus_sel
            assign _adev_sel[gi] = ~(exec_q && (abus_dev == 3'(gi)));
            assign _bdev_sel[gi] = ~(exec_q && (bbus_dev == 3'(gi)));
        end
        for (gi = 0; gi < 16; gi++) begin : g_targ_sel
            assign _tdev_sel[gi] = ~(!do_exec_n && (targ_dev == 4'(gi)));
        end
    endgenerate

endmodule

// File: tb/tb_controller_seq.sv
// Directed bench for controller_seq: byte-wide ROM instance plus a 48-bit-ROM, 4-bit-PC instance for wrap.
module tb_controller_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        _mr, rom_valid, stall, _pc_load;
    logic [7:0]  rom_data;
    logic [2:0]  rom_beat;
    logic [15:0] pc, pc_in;
    logic [9:0]  _flags;
    logic        exec, _addrmode_register, _addrmode_direct, _set_flags, _do_exec;
    logic [4:0]  alu_op;
    logic [2:0]  abus_dev, bbus_dev;
    logic [3:0]  targ_dev;
    logic [7:0]  direct_address_hi, direct_address_lo, immed8, _adev_sel, _bdev_sel;
    logic [15:0] _tdev_sel;
    logic [47:0] instr;
    logic [47:0] sh;

    always_comb begin
        sh       = instr >> (8 * (5 - int'(rom_beat)));
        rom_data = sh[7:0];
    end

    controller_seq #(.PCW(16), .ROMW(8), .NFLAGS(10)) u_dut (
        .clk(clk), ._mr(_mr), .rom_data(rom_data), .rom_valid(rom_valid), .rom_beat(rom_beat),
        .pc(pc), ._flags(_flags), .stall(stall), .pc_in(pc_in), ._pc_load(_pc_load), .exec(exec),
        .alu_op(alu_op), .abus_dev(abus_dev), .bbus_dev(bbus_dev), .targ_dev(targ_dev),
        .direct_address_hi(direct_address_hi), .direct_address_lo(direct_address_lo), .immed8(immed8),
        ._addrmode_register(_addrmode_register), ._addrmode_direct(_addrmode_direct),
        ._adev_sel(_adev_sel), ._bdev_sel(_bdev_sel), ._tdev_sel(_tdev_sel),
        ._set_flags(_set_flags), ._do_exec(_do_exec)
    );

    logic [47:0] s_rom_data = 48'h0;
    logic        s_rom_beat;
    logic [3:0]  s_pc;
    logic [14:0] s_flags = '1;
    logic        s_exec, s_amr, s_amd, s_set_flags, s_do_exec;
    logic [4:0]  s_alu;
    logic [2:0]  s_abus, s_bbus;
    logic [3:0]  s_targ;
    logic [7:0]  s_hi, s_lo, s_imm, s_adev, s_bdev;
    logic [15:0] s_tdev;

    controller_seq #(.PCW(4), .ROMW(48), .NFLAGS(15)) u_small (
        .clk(clk), ._mr(_mr), .rom_data(s_rom_data), .rom_valid(1'b1), .rom_beat(s_rom_beat),
        .pc(s_pc), ._flags(s_flags), .stall(1'b0), .pc_in(4'h0), ._pc_load(1'b1), .exec(s_exec),
        .alu_op(s_alu), .abus_dev(s_abus), .bbus_dev(s_bbus), .targ_dev(s_targ),
        .direct_address_hi(s_hi), .direct_address_lo(s_lo), .immed8(s_imm),
        ._addrmode_register(s_amr), ._addrmode_direct(s_amd),
        ._adev_sel(s_adev), ._bdev_sel(s_bdev), ._tdev_sel(s_tdev),
        ._set_flags(s_set_flags), ._do_exec(s_do_exec)
    );

    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic fetch(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!exec && n < 40);
        chk("fetch_reaches_exec", {47'd0, exec}, 48'd1);
        $display("exec pc=%04h cycles=%0d alu=%02h targ=%0d tdev=%04h", pc, n, alu_op, targ_dev, _tdev_sel);
    endtask

    function automatic logic [47:0] mk(input logic [4:0] alu, input logic [3:0] t, input logic [2:0] a,
                                       input logic [2:0] b, input logic [3:0] c, input logic sf,
                                       input logic am, input logic [7:0] hi, input logic [7:0] lo,
                                       input logic [7:0] imm);
        return {alu, t, a, b, c, sf, 3'b000, am, hi, lo, imm};
    endfunction

    localparam logic [47:0] I1 = 48'h8A36_1012_3456;

    initial begin
        int n;
        int found;
        logic [15:0] exp_pc;

        _mr = 1'b0; rom_valid = 1'b0; instr = '0; _flags = '1; stall = 1'b0;
        pc_in = 16'h0200; _pc_load = 1'b1;
        step(); step();
        chk("rst_pc", pc, 0);
        chk("rst_beat", rom_beat, 0);
        chk("rst_exec", exec, 0);
        chk("rst_adev", _adev_sel, 8'hFF);
        chk("rst_bdev", _bdev_sel, 8'hFF);
        chk("rst_tdev", _tdev_sel, 16'hFFFF);
        chk("rst_set_flags", _set_flags, 1);
        chk("rst_do_exec", _do_exec, 1);

        // Plain instruction, zero-wait ROM
        _mr = 1'b1; instr = I1; rom_valid = 1'b1;
        fetch(n);
        chk("i1_latency", n, 6);
        chk("i1_alu", alu_op, 5'h11);
        chk("i1_targ", targ_dev, 4);
        chk("i1_abus", abus_dev, 3);
        chk("i1_bbus", bbus_dev, 3);
        chk("i1_do_exec", _do_exec, 0);
        chk("i1_tdev", _tdev_sel, 16'hFFEF);
        chk("i1_adev", _adev_sel, 8'hF7);
        chk("i1_imm", immed8, 8'h56);
        chk("i1_daddr", {direct_address_hi, direct_address_lo}, 16'h1234);
        chk("i1_amr", _addrmode_register, 0);
        chk("i1_amd", _addrmode_direct, 1);
        chk("i1_pc", pc, 0);
        step();
        chk("i1_pc_next", pc, 1);
        chk("i1_exec_drop", exec, 0);

        // cond=3: flag inactive then active; stall holds EXEC
        instr = mk(5'h02, 4'd7, 3'd1, 3'd6, 4'd3, 1'b0, 1'b1, 8'hAB, 8'hCD, 8'hEF);
        stall = 1'b1; _flags = '1;
        fetch(n);
        chk("c3_latency", n, 6);
        chk("c3_false_do", _do_exec, 1);
        chk("c3_false_tdev", _tdev_sel, 16'hFFFF);
        chk("c3_false_sf", _set_flags, 1);
        chk("c3_adev", _adev_sel, 8'hFD);
        chk("c3_bdev", _bdev_sel, 8'hBF);
        chk("c3_amr", _addrmode_register, 1);
        _flags[2] = 1'b0;
        #1;
        chk("c3_true_do", _do_exec, 0);
        chk("c3_true_tdev", _tdev_sel, 16'hFF7F);
        chk("c3_true_sf", _set_flags, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_exec", exec, 1);
            chk("stall_pc", pc, 1);
            chk("stall_tdev", _tdev_sel, 16'hFF7F);
        end
        stall = 1'b0;
        step();
        chk("stall_release_pc", pc, 2);
        chk("stall_release_exec", exec, 0);
        step();
        chk("stall_single_inc", pc, 2);

        // cond=15 never, cond=10 boundary executes, cond=11 never
        instr = mk(5'h03, 4'd2, 3'd0, 3'd0, 4'd15, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01);
        _flags = '0;
        fetch(n);
        chk("c15_do", _do_exec, 1);
        chk("c15_tdev", _tdev_sel, 16'hFFFF);
        chk("c15_sf", _set_flags, 1);
        step();
        chk("c15_pc", pc, 3);
        instr = mk(5'h04, 4'd9, 3'd2, 3'd2, 4'd10, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02);
        fetch(n);
        chk("c10_tdev", _tdev_sel, 16'hFDFF);
        chk("c10_sf", _set_flags, 0);
        step();
        instr = mk(5'h05, 4'd9, 3'd2, 3'd2, 4'd11, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03);
        fetch(n);
        chk("c11_do", _do_exec, 1);
        step();
        chk("c11_pc", pc, 5);

        // ROM wait states at beat 2
        instr = I1; _flags = '1;
        step(); step();
        chk("wait_beat_before", rom_beat, 2);
        rom_valid = 1'b0; instr = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_beat_hold", rom_beat, 2);
            chk("wait_no_exec", exec, 0);
        end
        rom_valid = 1'b1; instr = I1;
        fetch(n);
        chk("wait_rest_latency", n, 4);
        chk("wait_imm", immed8, 8'h56);
        chk("wait_alu", alu_op, 5'h11);
        chk("wait_daddr", {direct_address_hi, direct_address_lo}, 16'h1234);
        step();
        chk("wait_pc", pc, 6);

        // Reset mid-fetch at beat 3
        step(); step(); step();
        chk("mr_beat_before", rom_beat, 3);
        _mr = 1'b0;
        #1;
        chk("mr_pc", pc, 0);
        chk("mr_beat", rom_beat, 0);
        chk("mr_exec", exec, 0);
        chk("mr_tdev", _tdev_sel, 16'hFFFF);
        chk("mr_adev", _adev_sel, 8'hFF);
        chk("mr_do_exec", _do_exec, 1);
        step();
        _mr = 1'b1;
        fetch(n);
        chk("mr_refetch_latency", n, 6);
        chk("mr_refetch_pc", pc, 0);

        // Jump request: condition true, then condition false
        _pc_load = 1'b0;
`ifdef CTRL_JUMP_EN
        exp_pc = 16'h0200;
`else
        exp_pc = 16'h0001;
`endif
        step();
        chk("jmp_true_pc", pc, exp_pc);
        instr = mk(5'h06, 4'd1, 3'd0, 3'd0, 4'd15, 1'b1, 1'b0, 8'h00, 8'h00, 8'h04);
        fetch(n);
        step();
        chk("jmp_false_pc", pc, exp_pc + 16'd1);
        _pc_load = 1'b1;

        // Narrow-PC instance: 1-cycle fetch and wrap from max to 0
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (s_pc == 4'hF && !s_exec) found = 1;
            else step();
        end
        chk("wrap_found", found, 1);
        step();
        chk("wrap_exec_1cyc", s_exec, 1);
        chk("wrap_pc_max", s_pc, 4'hF);
        chk("wrap_beat", s_rom_beat, 0);
        step();
        chk("wrap_pc_zero", s_pc, 0);
        chk("wrap_exec_drop", s_exec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
